// File: rtl/hsm_mem_arbiter_pkg.sv
// Shared definitions for the HSM memory arbiter: FSM states and default geometry.
package hsm_mem_arbiter_pkg;

  localparam int unsigned DEPTH_DEFAULT  = 1024;
  localparam int unsigned ADDR_W_DEFAULT = 10;

  typedef enum logic [1:0] {
    StClear,
    StIdle,
    StAccess,
    StResp
  } state_e;

endpackage

// File: rtl/hsm_mem_arbiter.sv
// Arbitrates one CPU port against a zeroize engine in front of a single-port memory.
// Zeroize runs after every reset and on request; a CPU access in flight always completes
// before a requested zeroize starts.
module hsm_mem_arbiter
  import hsm_mem_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH  = DEPTH_DEFAULT,
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_valid,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic [3:0]        cpu_wstrb,
  output logic              cpu_ready,
  output logic [31:0]       cpu_rdata,
  input  logic              clear_req,
  output logic              clear_busy,
  output logic              clear_done,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic [31:0]       mem_rdata
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic              pending_q, pending_d;
  logic              done_q, done_d;

  // State, clear counter, captured request and pending-clear flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StClear;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      pending_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      pending_q <= pending_d;
      done_q    <= done_d;
    end
  end

  // Next-state: zeroize sweep, request capture, and deferred clear after a CPU access.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    pending_d = pending_q;
    done_d    = 1'b0;
    unique case (state_q)
      StClear: begin
        // clear_req is ignored here so the sweep never restarts.
        if (cnt_q == LastAddr) begin
          state_d = StIdle;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      StIdle: begin
        if (clear_req) begin
          state_d = StClear;
          cnt_d   = '0;
        end else if (cpu_valid) begin
          state_d = StAccess;
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          wstrb_d = cpu_wstrb;
        end
      end
      StAccess: begin
        if (clear_req) pending_d = 1'b1;
        state_d = StResp;
      end
      StResp: begin
        if (pending_q || clear_req) begin
          state_d   = StClear;
          cnt_d     = '0;
          pending_d = 1'b0;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StClear;
    endcase
  end

  // Outputs decoded from the current state; memory strobes held low while reset is applied.
  always_comb begin
    cpu_ready  = 1'b0;
    cpu_rdata  = '0;
    clear_busy = 1'b0;
    mem_en     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_wstrb  = '0;
    unique case (state_q)
      StClear: begin
        clear_busy = 1'b1;
        mem_en     = ~reset;
        mem_addr   = cnt_q;
        mem_wstrb  = reset ? 4'h0 : 4'hF;
      end
      StAccess: begin
        mem_en    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_wstrb = wstrb_q;
      end
      StResp: begin
        cpu_ready = 1'b1;
        if (wstrb_q == 4'h0) cpu_rdata = mem_rdata;
      end
      default: ;
    endcase
  end

  assign clear_done = done_q;

endmodule

// File: tb/tb_hsm_mem_arbiter.sv
// Self-checking bench for hsm_mem_arbiter: behavioural model compared every cycle,
// directed scenarios with literal expectations, then randomized CPU/clear traffic.
module tb_hsm_mem_arbiter;
  import hsm_mem_arbiter_pkg::*;

  localparam int unsigned DEPTH  = DEPTH_DEFAULT;
  localparam int unsigned ADDR_W = ADDR_W_DEFAULT;
  localparam int          OUT_W  = 1 + 32 + 1 + 1 + 1 + ADDR_W + 32 + 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              cpu_valid = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [31:0]       cpu_wdata = '0;
  logic [3:0]        cpu_wstrb = '0;
  logic              cpu_ready;
  logic [31:0]       cpu_rdata;
  logic              clear_req = 1'b0;
  logic              clear_busy;
  logic              clear_done;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wstrb;
  logic [31:0]       mem_rdata = '0;

  logic [31:0] ram [DEPTH];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hsm_mem_arbiter #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_valid (cpu_valid),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_wstrb (cpu_wstrb),
    .cpu_ready (cpu_ready),
    .cpu_rdata (cpu_rdata),
    .clear_req (clear_req),
    .clear_busy(clear_busy),
    .clear_done(clear_done),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata)
  );

  // Single-port RAM with one-cycle read latency and byte enables.
  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata <= ram[mem_addr];
      for (int b = 0; b < 4; b++)
        if (mem_wstrb[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  // ---------------- behavioural model ----------------
  int                clr_left;   // words still to zeroize; 0 when not clearing
  int                phase;      // 0 no transaction, 1 memory access, 2 response
  bit                pend;
  bit                done_exp;
  bit                done_n;
  logic [ADDR_W-1:0] t_addr;
  logic [31:0]       t_wdata, rd_exp;
  logic [3:0]        t_wstrb;
  logic [31:0]       gold [DEPTH];

  initial begin
    clr_left = int'(DEPTH); phase = 0; pend = 0; done_exp = 0;
    t_addr = '0; t_wdata = '0; t_wstrb = '0; rd_exp = '0;
    for (int i = 0; i < int'(DEPTH); i++) gold[i] = '0;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        clr_left = int'(DEPTH); phase = 0; pend = 0; done_exp = 0;
      end else begin
        done_n = 0;
        if (clr_left > 0) begin
          gold[int'(DEPTH) - clr_left] = '0;
          clr_left--;
          done_n = (clr_left == 0);
        end else if (phase == 1) begin
          if (t_wstrb == 4'h0) rd_exp = gold[t_addr];
          for (int b = 0; b < 4; b++)
            if (t_wstrb[b]) gold[t_addr][8*b +: 8] = t_wdata[8*b +: 8];
          if (clear_req) pend = 1;
          phase = 2;
        end else if (phase == 2) begin
          phase = 0;
          if (pend || clear_req) begin clr_left = int'(DEPTH); pend = 0; end
        end else if (clear_req) begin
          clr_left = int'(DEPTH);
        end else if (cpu_valid) begin
          t_addr = cpu_addr; t_wdata = cpu_wdata; t_wstrb = cpu_wstrb; phase = 1;
        end
        done_exp = done_n;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model (or reset values).
  initial begin
    logic [OUT_W-1:0] act, exv;
    bit clearing, acc, resp;
    forever begin
      @(negedge clk);
      act = {cpu_ready, cpu_rdata, clear_busy, clear_done, mem_en, mem_addr, mem_wdata,
             mem_wstrb};
      if (reset) begin
        exv = {1'b0, 32'h0, 1'b1, 1'b0, 1'b0, {ADDR_W{1'b0}}, 32'h0, 4'h0};
      end else begin
        clearing = clr_left > 0;
        acc      = phase == 1;
        resp     = phase == 2;
        exv = {resp, (resp && t_wstrb == 4'h0) ? rd_exp : 32'h0, clearing, done_exp,
               clearing || acc,
               clearing ? ADDR_W'(int'(DEPTH) - clr_left) : (acc ? t_addr : {ADDR_W{1'b0}}),
               acc ? t_wdata : 32'h0,
               clearing ? 4'hF : (acc ? t_wstrb : 4'h0)};
      end
      checks++;
      if (act !== exv) begin
        failures++;
        if (failures <= 20)
          $display("FAIL cycle_compare t=%0t actual=%h required=%h", $time, act, exv);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exv);
    checks++;
    if (act !== exv) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exv);
    end
  endtask

  // Called just after a rising edge; lat counts falling edges until cpu_ready is seen,
  // starting with the one before the edge that samples cpu_valid.
  task automatic cpu_txn(input logic [ADDR_W-1:0] a, input logic [31:0] d,
                         input logic [3:0] s, input int clr_at,
                         output logic [31:0] rd, output int lat);
    int n;
    n = 0; lat = -1; rd = '0;
    cpu_valid = 1'b1; cpu_addr = a; cpu_wdata = d; cpu_wstrb = s;
    clear_req = (clr_at == 0);
    while (lat < 0 && n < 5000) begin
      @(negedge clk); n++;
      if (cpu_ready) begin lat = n; rd = cpu_rdata; end
      @(posedge clk); #1;
      clear_req = (clr_at == n);
    end
    cpu_valid = 1'b0; clear_req = 1'b0;
    if (lat < 0) begin
      checks++; failures++;
      $display("FAIL txn_timeout actual=no_ready required=ready");
    end
  endtask

  // Counts falling edges up to and including the clear_done one, and zero writes before it.
  task automatic wait_clear(output int n, output int w);
    n = 0; w = 0;
    while (n < 3000) begin
      @(negedge clk); n++;
      if (clear_done) break;
      if (mem_en && mem_wstrb == 4'hF && mem_wdata == 32'h0) w++;
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_addr(input int a);
    bit ok;
    ok = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      if (clear_busy && mem_addr == ADDR_W'(a)) ok = 1;
    end
    check("wait_clear_addr", 64'(ok), 64'd1);
  endtask

  task automatic pulse_clear();
    clear_req = 1'b1;
    @(posedge clk); #1;
    clear_req = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, w, lat, clr, gap;
    logic [31:0] rd;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_clear_busy", 64'(clear_busy), 64'd1);
    check("reset_mem_en", 64'(mem_en), 64'd0);
    @(posedge clk); #1 reset = 1'b0;

    // Boot zeroize: 1024 consecutive writes, done in the following cycle.
    wait_clear(n, w);
    check("boot_clear_cycles", 64'(n), 64'd1025);
    check("boot_clear_writes", 64'(w), 64'd1024);

    // Write then read back, full and partial strobes.
    cpu_txn(10'd5, 32'hDEADBEEF, 4'hF, -1, rd, lat);
    check("write5_latency", 64'(lat), 64'd3);
    check("write5_rdata_zero", 64'(rd), 64'd0);
    cpu_txn(10'd5, 32'h0, 4'h0, -1, rd, lat);
    check("read5_latency", 64'(lat), 64'd3);
    check("read5_rdata", 64'(rd), 64'hDEADBEEF);
    cpu_txn(10'd5, 32'h11112222, 4'h3, -1, rd, lat);
    cpu_txn(10'd5, 32'h0, 4'h0, -1, rd, lat);
    check("read5_partial", 64'(rd), 64'hDEAD2222);

    // Simultaneous clear and read in idle: clear runs first, word reads back zero.
    cpu_txn(10'd5, 32'h0, 4'h0, 0, rd, lat);
    check("clear_first_latency", 64'(lat), 64'd1028);
    check("clear_first_rdata", 64'(rd), 64'd0);

    // Clear during the access of a write: write completes, then the sweep wipes it.
    cpu_txn(10'd7, 32'hCAFEF00D, 4'hF, 1, rd, lat);
    check("deferred_write_latency", 64'(lat), 64'd3);
    wait_clear(n, w);
    check("deferred_clear_cycles", 64'(n), 64'd1025);
    cpu_txn(10'd7, 32'h0, 4'h0, -1, rd, lat);
    check("deferred_read7", 64'(rd), 64'd0);

    // Reset in the middle of a sweep restarts it from word 0.
    pulse_clear();
    wait_addr(500);
    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1 reset = 1'b0;
    wait_clear(n, w);
    check("reset_restart_cycles", 64'(n), 64'd1025);
    check("reset_restart_writes", 64'(w), 64'd1024);

    // clear_req during a sweep is ignored; done arrives at the original time.
    pulse_clear();
    wait_addr(300);
    clear_req = 1'b1;
    @(posedge clk); #1 clear_req = 1'b0;
    wait_clear(n, w);
    check("ignored_clear_cycles", 64'(n), 64'd724);
    check("ignored_clear_writes", 64'(w), 64'd723);

    // Randomized traffic over a small address window, occasional clears.
    for (int i = 0; i < 200; i++) begin
      clr = ($urandom_range(0, 39) == 0) ? int'($urandom_range(0, 2)) : -1;
      cpu_txn(ADDR_W'($urandom_range(0, 15)), $urandom,
              ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom), clr, rd, lat);
      gap = int'($urandom_range(0, 2));
      repeat (gap) begin
        @(posedge clk); #1;
      end
    end
    repeat (1100) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hsm_mem_arbiter.md
HSM_MEM_ARBITER -- requirements
Module: hsm_mem_arbiter

Interface
REQ-001 Parameter DEPTH, default 1024: words in the shared memory.
REQ-002 Parameter ADDR_W, default 10: word-address width, equal to log2(DEPTH).
REQ-003 clk  in  1  sole clock; all state changes on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 cpu_valid  in  1  CPU request, held until cpu_ready.
REQ-006 cpu_addr  in  ADDR_W  CPU word address.
REQ-007 cpu_wdata  in  32  CPU write data.
REQ-008 cpu_wstrb  in  4  byte write enables; 0 means read.
REQ-009 cpu_ready  out  1  one-cycle completion pulse.
REQ-010 cpu_rdata  out  32  read data, valid while cpu_ready=1.
REQ-011 clear_req  in  1  zeroize request pulse.
REQ-012 clear_busy  out  1  high while zeroizing.
REQ-013 clear_done  out  1  one-cycle pulse when zeroize completes.
REQ-014 mem_en  out  1  memory access strobe.
REQ-015 mem_addr  out  ADDR_W  memory word address.
REQ-016 mem_wdata  out  32  memory write data.
REQ-017 mem_wstrb  out  4  memory byte enables.
REQ-018 mem_rdata  in  32  memory read data, valid one cycle after mem_en.

Function
REQ-019 FSM states: CLEAR, IDLE, ACCESS, RESP.
REQ-020 CLEAR: mem_en=1, mem_wstrb=4'hF, mem_wdata=0, mem_addr=clear counter, one word per cycle.
REQ-021 Clear counter starts at 0 and increments each CLEAR cycle; the cycle with counter=DEPTH-1 is the last write, with no wrap.
REQ-022 After the DEPTH-1 write, go to IDLE, pulse clear_done for exactly one cycle, and clear_busy=0 from that cycle on.
REQ-023 clear_busy=1 in every CLEAR cycle; zeroize takes exactly DEPTH cycles.
REQ-024 IDLE with clear_req=1 goes to CLEAR with counter=0; clear_req has priority over a simultaneous cpu_valid.
REQ-025 IDLE with cpu_valid=1 and clear_req=0 captures cpu_addr, cpu_wdata and cpu_wstrb into registers and goes to ACCESS.
REQ-026 ACCESS: mem_en=1 with the captured address, data and strobe; next state RESP.
REQ-027 RESP: cpu_ready=1 and cpu_rdata=mem_rdata.
REQ-028 cpu_rdata is 0 for writes and whenever cpu_ready=0.
REQ-029 After RESP, go to CLEAR if a clear is pending, else IDLE.
REQ-030 CPU latency: cpu_ready is asserted 2 cycles after the edge that samples cpu_valid in IDLE.
REQ-031 A request arriving in RESP is not accepted until IDLE, so back-to-back transactions take 3 cycles each.
REQ-032 clear_req in ACCESS or RESP sets a pending flag; the in-flight CPU transaction completes first; the pending flag clears on entry to CLEAR.
REQ-033 clear_req during CLEAR is ignored; the counter does not restart.
REQ-034 cpu_valid during CLEAR is stalled: cpu_ready=0 and the request is held until IDLE.
REQ-035 Outside CLEAR and ACCESS: mem_en=0, mem_wstrb=0.

Reset
REQ-036 Reset asserted enters CLEAR with counter=0 and pending=0; memory is zeroized after every reset.
REQ-037 Reset values: cpu_ready=0, cpu_rdata=0, clear_done=0, clear_busy=1, mem_en=0, mem_addr=0, mem_wdata=0, mem_wstrb=0.
REQ-038 Reset mid-operation aborts any transaction or zeroize with no cpu_ready or clear_done pulse; zeroize restarts from word 0.

Structure
REQ-039 The shared package holds the FSM state enum (CLEAR, IDLE, ACCESS, RESP) and the DEPTH and ADDR_W defaults.
REQ-040 The block is one flat module with no sub-modules; one instance sits in front of each of ram and fram in the SoC.

Verification
REQ-041 Release reset, no requests -> mem writes 0 to addresses 0..1023 on consecutive cycles, clear_done pulses once at cycle 1024, then IDLE.
REQ-042 Write addr 5 = 32'hDEADBEEF with wstrb 4'hF, then read addr 5 -> read cpu_ready 2 cycles after valid, cpu_rdata=32'hDEADBEEF.
REQ-043 In IDLE, clear_req and cpu_valid in the same cycle -> CLEAR runs first, cpu_ready follows 1024+3 cycles after valid, read of a prior-written word returns 0.
REQ-044 clear_req in ACCESS of a write -> write completes with cpu_ready, then CLEAR starts; the word reads back 0 afterwards.
REQ-045 Assert reset at counter=500 -> counter restarts at 0, no clear_done until 1024 writes after release.
REQ-046 clear_req at counter=300 -> ignored, clear_done at the original completion cycle only.
